// File: rtl/cai_ring_ctrl.sv
// CAI ring controller: per-channel submit/completion ring indices, slot address
// and tag allocation, doorbell pulses, in-order tag checking and a completion
// watchdog with sticky error flags.
module cai_ring_ctrl #(
    parameter int NUM_CH            = 2,
    parameter int DEPTH_LOG2        = 2,
    parameter int ADDR_W            = 32,
    parameter int TAG_W             = 32,
    parameter int SUBMIT_DESC_BYTES = 64,
    parameter int COMP_REC_BYTES    = 16,
    parameter int TIMEOUT_CYCLES    = 20000,
    parameter int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*ADDR_W-1:0]       submit_base,
    input  logic [NUM_CH*ADDR_W-1:0]       comp_base,
    input  logic                           sub_valid,
    input  logic [CH_W-1:0]                sub_ch,
    output logic                           sub_ready,
    output logic [ADDR_W-1:0]              sub_addr,
    output logic [TAG_W-1:0]               sub_tag,
    output logic [NUM_CH-1:0]              submit_doorbell,
    input  logic                           comp_valid,
    input  logic [CH_W-1:0]                comp_ch,
    input  logic [TAG_W-1:0]               comp_tag,
    output logic [NUM_CH*ADDR_W-1:0]       comp_rec_addr,
    output logic [NUM_CH*(DEPTH_LOG2+1)-1:0] outstanding,
    output logic [NUM_CH-1:0]              err_tag,
    output logic [NUM_CH-1:0]              err_spurious,
    output logic [NUM_CH-1:0]              err_timeout,
    input  logic                           err_clr
);

    localparam int IW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0]   MASK    = IW'(DEPTH - 1);
    localparam logic [IW-1:0]   FULL_N  = IW'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    logic [IW-1:0]    sidx [NUM_CH];
    logic [IW-1:0]    cidx [NUM_CH];
    logic [IW-1:0]    occ  [NUM_CH];
    logic [WD_W-1:0]  wdog [NUM_CH];
    logic [TAG_W-1:0] tags [NUM_CH][DEPTH];
    logic [TAG_W-1:0] tag_ctr;

    logic              sub_ch_ok;
    logic              comp_ch_ok;
    logic              sub_fire;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] comp_hit;
    logic [NUM_CH-1:0] comp_adv;
    logic [NUM_CH-1:0] tag_ev;
    logic [NUM_CH-1:0] spur_ev;
    logic [NUM_CH-1:0] to_ev;

    // Ring slot inside the tag array / address window for a free-running index.
    function automatic logic [SW-1:0] slot_of(input logic [IW-1:0] idx);
        return SW'(idx & MASK);
    endfunction

    // Occupancy, full flags and per-channel completion record addresses.
    always_comb begin
        full          = '0;
        comp_rec_addr = '0;
        outstanding   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            occ[ch]  = sidx[ch] - cidx[ch];
            full[ch] = (occ[ch] == FULL_N);
            outstanding[ch*IW +: IW] = occ[ch];
            comp_rec_addr[ch*ADDR_W +: ADDR_W] = comp_base[ch*ADDR_W +: ADDR_W]
                + ADDR_W'(slot_of(cidx[ch])) * ADDR_W'(COMP_REC_BYTES);
        end
    end

    // Submit-side handshake: slot address and tag offered for the requested channel.
    always_comb begin
        sub_ch_ok  = (int'(sub_ch) < NUM_CH);
        comp_ch_ok = (int'(comp_ch) < NUM_CH);
        sub_ready  = sub_ch_ok && !full[sub_ch];
        sub_fire   = sub_valid && sub_ready;
        sub_tag    = tag_ctr;
        sub_addr   = submit_base[int'(sub_ch)*ADDR_W +: ADDR_W]
                   + ADDR_W'(slot_of(sidx[sub_ch])) * ADDR_W'(SUBMIT_DESC_BYTES);
    end

    // Completion classification and watchdog expiry, all from pre-cycle state.
    always_comb begin
        comp_hit = '0;
        comp_adv = '0;
        tag_ev   = '0;
        spur_ev  = '0;
        to_ev    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            comp_hit[ch] = comp_valid && comp_ch_ok && (comp_ch == CH_W'(ch));
            if (comp_hit[ch]) begin
                if (occ[ch] == '0) begin
                    spur_ev[ch] = 1'b1;
                end else begin
                    comp_adv[ch] = 1'b1;
                    tag_ev[ch]   = (comp_tag != tags[ch][slot_of(cidx[ch])]);
                end
            end
            if (!comp_hit[ch] && (occ[ch] != '0) && (wdog[ch] == WD_LAST))
                to_ev[ch] = 1'b1;
        end
    end

    // Ring indices, tag counter, watchdogs, doorbell pulses and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sidx[ch] <= '0;
                cidx[ch] <= '0;
                wdog[ch] <= '0;
            end
            tag_ctr         <= TAG_W'(1);
            submit_doorbell <= '0;
            err_tag         <= '0;
            err_spurious    <= '0;
            err_timeout     <= '0;
        end else begin
            submit_doorbell <= '0;
            if (sub_fire) begin
                sidx[sub_ch]            <= sidx[sub_ch] + IW'(1);
                tag_ctr                 <= (&tag_ctr) ? TAG_W'(1) : tag_ctr + TAG_W'(1);
                submit_doorbell[sub_ch] <= 1'b1;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (comp_adv[ch])
                    cidx[ch] <= cidx[ch] + IW'(1);
                if (comp_hit[ch] || (occ[ch] == '0))
                    wdog[ch] <= '0;
                else if (wdog[ch] != WD_MAX)
                    wdog[ch] <= wdog[ch] + WD_W'(1);
            end
            err_tag      <= (err_tag      & ~{NUM_CH{err_clr}}) | tag_ev;
            err_spurious <= (err_spurious & ~{NUM_CH{err_clr}}) | spur_ev;
            err_timeout  <= (err_timeout  & ~{NUM_CH{err_clr}}) | to_ev;
        end
    end

    // Expected-tag storage, written at the submit slot on each accepted request.
    always_ff @(posedge clk) begin
        if (sub_fire)
            tags[sub_ch][slot_of(sidx[sub_ch])] <= tag_ctr;
    end

endmodule
